// File: rtl/axi_id_killer_pkg.sv
// Shared types and constants for the AXI ID killer blocks.
package axi_id_killer_pkg;

    localparam int AXI_LEN_W = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axiResp_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HELD  = 1'b1
    } arSlot_e;

    function automatic int countWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/axi_id_killer_rd_sched_if.sv
// AR/R channel bundle around the read scheduler: upstream (s_*) and downstream (m_*) sides.
interface axi_id_killer_rd_sched_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]                      s_arid;
    logic [ADDR_WIDTH-1:0]                    s_araddr;
    logic [axi_id_killer_pkg::AXI_LEN_W-1:0]  s_arlen;
    logic                                     s_arvalid;
    logic                                     s_arready;

    logic [ADDR_WIDTH-1:0]                    m_araddr;
    logic [axi_id_killer_pkg::AXI_LEN_W-1:0]  m_arlen;
    logic                                     m_arvalid;
    logic                                     m_arready;

    logic [DATA_WIDTH-1:0]                    m_rdata;
    logic [1:0]                               m_rresp;
    logic                                     m_rlast;
    logic                                     m_rvalid;
    logic                                     m_rready;

    logic [ID_WIDTH-1:0]                      s_rid;
    logic [DATA_WIDTH-1:0]                    s_rdata;
    logic [1:0]                               s_rresp;
    logic                                     s_rlast;
    logic                                     s_rvalid;
    logic                                     s_rready;

    // The scheduler sits on the slave modport; the surrounding fabric uses master.
    modport slave (
        input  s_arid, s_araddr, s_arlen, s_arvalid,
        output s_arready,
        output m_araddr, m_arlen, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );

    modport master (
        output s_arid, s_araddr, s_arlen, s_arvalid,
        input  s_arready,
        input  m_araddr, m_arlen, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );

endinterface

// File: rtl/axi_id_killer_fifo.sv
// In-order ID FIFO with synchronous reset; head is presented combinationally on rdata.
module axi_id_killer_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             rempty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush, doPop;

    assign wfull  = (count_q == FULL_CNT);
    assign rempty = (count_q == '0);
    assign doPush = winc && !wfull;
    assign doPop  = rinc && !rempty;
    assign rdata  = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (rst) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = (wrPtr_q == LAST_IDX) ? '0 : wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_d = (rdPtr_q == LAST_IDX) ? '0 : rdPtr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        wrPtr_q <= wrPtr_d;
        rdPtr_q <= rdPtr_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/axi_id_killer_rd_sched.sv
// Read-side ID killer: issues ARs downstream without ID and re-tags in-order R beats
// from an ID FIFO, with an outstanding limit and a drain/idle handshake.
module axi_id_killer_rd_sched
    import axi_id_killer_pkg::*;
#(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    axi_id_killer_rd_sched_if.slave                bus,
    input  logic                                   drain,
    output logic                                   idle,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   proto_err
);

    localparam int CNT_W = countWidth(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    arSlot_e                slotState_q, slotState_d;
    logic [ADDR_WIDTH-1:0]  arAddr_q, arAddr_d;
    logic [AXI_LEN_W-1:0]   arLen_q, arLen_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic                   protoErr_q, protoErr_d;

    logic                   fifoFull, fifoEmpty;
    logic [ID_WIDTH-1:0]    fifoHead;
    logic                   arReady, arAccept, rReady, rLastPop;
    logic [DATA_WIDTH-1:0]  rData;
    axiResp_e               rResp;

    // Ready is forced low while reset is asserted so the FIFO, which only clears
    // on an edge, can never be pushed from stale state.
    assign arReady  = !rst && (slotState_q == SLOT_EMPTY) && !drain && !fifoFull
                      && (outstanding_q < MAX_CNT);
    assign arAccept = bus.s_arvalid && arReady;
    assign rReady   = bus.s_rready && !fifoEmpty;
    assign rLastPop = bus.m_rvalid && rReady && bus.m_rlast;

    axi_id_killer_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_idFifo (
        .clk    (clk),
        .rst    (rst),
        .winc   (arAccept),
        .wdata  (bus.s_arid),
        .wfull  (fifoFull),
        .rinc   (rLastPop),
        .rdata  (fifoHead),
        .rempty (fifoEmpty)
    );

    always_comb begin
        slotState_d   = slotState_q;
        arAddr_d      = arAddr_q;
        arLen_d       = arLen_q;
        outstanding_d = outstanding_q;
        protoErr_d    = protoErr_q;

        case (slotState_q)
            SLOT_EMPTY: begin
                if (arAccept) begin
                    arAddr_d    = bus.s_araddr;
                    arLen_d     = bus.s_arlen;
                    slotState_d = SLOT_HELD;
                end
            end
            SLOT_HELD: begin
                if (bus.m_arready) begin
                    slotState_d = SLOT_EMPTY;
                end
            end
            default: slotState_d = SLOT_EMPTY;
        endcase

        case ({arAccept, rLastPop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (bus.m_rvalid && fifoEmpty) begin
            protoErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotState_q   <= SLOT_EMPTY;
            arAddr_q      <= '0;
            arLen_q       <= '0;
            outstanding_q <= '0;
            protoErr_q    <= 1'b0;
        end else begin
            slotState_q   <= slotState_d;
            arAddr_q      <= arAddr_d;
            arLen_q       <= arLen_d;
            outstanding_q <= outstanding_d;
            protoErr_q    <= protoErr_d;
        end
    end

    assign bus.s_arready = arReady;
    assign bus.m_arvalid = (slotState_q == SLOT_HELD);
    assign bus.m_araddr  = arAddr_q;
    assign bus.m_arlen   = arLen_q;

    assign rData         = bus.m_rdata;
    assign rResp         = axiResp_e'(bus.m_rresp);
    assign bus.m_rready  = rReady;
    assign bus.s_rvalid  = bus.m_rvalid && !fifoEmpty;
    assign bus.s_rid     = fifoHead;
    assign bus.s_rdata   = rData;
    assign bus.s_rresp   = rResp;
    assign bus.s_rlast   = bus.m_rlast;

    assign idle          = (slotState_q == SLOT_EMPTY) && (outstanding_q == '0);
    assign outstanding   = outstanding_q;
    assign proto_err     = protoErr_q;

endmodule

// File: tb/tb_axi_id_killer_rd_sched.sv
// Randomized bench for the read scheduler: an ID-order scoreboard plus a transaction-level
// model of the upstream master and downstream slave.
module tb_axi_id_killer_rd_sched;
    import axi_id_killer_pkg::*;

    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 8;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ID_W-1:0]   sArId;
    logic [ADDR_W-1:0] sArAddr;
    logic [7:0]        sArLen;
    logic              sArValid;
    logic              mArReady;
    logic [DATA_W-1:0] mRData;
    logic [1:0]        mRResp;
    logic              mRLast;
    logic              mRValid;
    logic              sRReady;
    logic              drain;
    logic              idle;
    logic [CNT_W-1:0]  outstanding;
    logic              protoErr;

    axi_id_killer_rd_sched_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) bus ();

    assign bus.s_arid    = sArId;
    assign bus.s_araddr  = sArAddr;
    assign bus.s_arlen   = sArLen;
    assign bus.s_arvalid = sArValid;
    assign bus.m_arready = mArReady;
    assign bus.m_rdata   = mRData;
    assign bus.m_rresp   = mRResp;
    assign bus.m_rlast   = mRLast;
    assign bus.m_rvalid  = mRValid;
    assign bus.s_rready  = sRReady;

    axi_id_killer_rd_sched #(
        .ID_WIDTH        (ID_W),
        .ADDR_WIDTH      (ADDR_W),
        .DATA_WIDTH      (DATA_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .drain       (drain),
        .idle        (idle),
        .outstanding (outstanding),
        .proto_err   (protoErr)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: IDs in acceptance order, bursts issued downstream, and a slot flag.
    logic [ID_W-1:0]   expIdQ[$];
    int                burstQ[$];
    int                beat;
    int                modelCount;
    bit                held;
    logic [ADDR_W-1:0] heldAddr;
    logic [7:0]        heldLen;
    bit                monEn;
    bit                checkLimit;
    bit                expectIdle;
    int                pArV, pArR, pRV, pRR;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        cmp("outstanding", outstanding, modelCount);
        cmp("m_arvalid", bus.m_arvalid, held);
        if (held) begin
            cmp("m_araddr", bus.m_araddr, heldAddr);
            cmp("m_arlen", bus.m_arlen, heldLen);
        end
        cmp("s_arready", bus.s_arready, (!held && !drain && modelCount < MAX_OUT));
        cmp("idle", idle, (!held && modelCount == 0));
        cmp("proto_err", protoErr, 1'b0);
        if (checkLimit) begin
            cmp("limit_outstanding", outstanding, MAX_OUT);
            cmp("limit_s_arready", bus.s_arready, 1'b0);
        end
        if (expectIdle) begin
            cmp("idle_after_drain", idle, 1'b1);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bit arAcc, mArHs, rHs, rLast;
            @(negedge clk);
            checkOutput();
            arAcc = sArValid && bus.s_arready;
            mArHs = bus.m_arvalid && mArReady;
            rHs   = mRValid && bus.m_rready;
            rLast = mRLast;
            @(posedge clk);
            if (mArHs) begin
                held = 1'b0;
                burstQ.push_back(int'(heldLen));
            end
            if (arAcc) begin
                modelCount++;
                held     = 1'b1;
                heldAddr = sArAddr;
                heldLen  = sArLen;
                expIdQ.push_back(sArId);
            end
            if (rHs) begin
                if (rLast) begin
                    modelCount--;
                    void'(burstQ.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            #1;
            if (!sArValid || arAcc) begin
                sArValid = ($urandom_range(0, 99) < pArV);
                sArId    = ID_W'($urandom);
                sArAddr  = $urandom;
                sArLen   = 8'($urandom_range(0, 3));
            end
            mArReady = ($urandom_range(0, 99) < pArR);
            sRReady  = ($urandom_range(0, 99) < pRR);
            if (!mRValid || rHs) begin
                if (burstQ.size() > 0 && $urandom_range(0, 99) < pRV) begin
                    mRValid = 1'b1;
                    mRLast  = (beat == burstQ[0]);
                    mRData  = $urandom;
                    mRResp  = 2'($urandom);
                end else begin
                    mRValid = 1'b0;
                    mRLast  = 1'b0;
                end
            end
        end
    endtask

    // R-channel monitor: every upstream beat must carry the oldest outstanding ID.
    always @(negedge clk) begin
        if (monEn && !rst) begin
            cmp("s_rvalid", bus.s_rvalid, mRValid && expIdQ.size() != 0);
            cmp("m_rready", bus.m_rready, sRReady && expIdQ.size() != 0);
            if (bus.s_rvalid && sRReady) begin
                if (expIdQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL r_beat: got beat id 0x%0h, required no beat (no ID queued) at %0t",
                             bus.s_rid, $time);
                end else begin
                    cmp("s_rid", bus.s_rid, expIdQ[0]);
                    cmp("s_rdata", bus.s_rdata, mRData);
                    cmp("s_rresp", bus.s_rresp, mRResp);
                    cmp("s_rlast", bus.s_rlast, mRLast);
                    if (mRLast) void'(expIdQ.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        sArId = '0; sArAddr = '0; sArLen = '0; sArValid = 1'b0;
        mArReady = 1'b0; mRData = '0; mRResp = '0; mRLast = 1'b0; mRValid = 1'b0;
        sRReady = 1'b0; drain = 1'b0;
        monEn = 1'b0; checkLimit = 1'b0; expectIdle = 1'b0;
        modelCount = 0; held = 1'b0; heldAddr = '0; heldLen = '0; beat = 0;

        @(negedge clk);
        cmp("rst_m_arvalid", bus.m_arvalid, 1'b0);
        cmp("rst_outstanding", outstanding, 0);
        cmp("rst_proto_err", protoErr, 1'b0);
        cmp("rst_idle", idle, 1'b1);
        cmp("rst_s_arready", bus.s_arready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        monEn = 1'b1;

        $display("[TB] mixed traffic");
        pArV = 60; pArR = 70; pRV = 70; pRR = 70;
        applyStimulus(400);

        $display("[TB] outstanding limit");
        pArV = 100; pArR = 100; pRV = 0; pRR = 100;
        applyStimulus(40);
        checkLimit = 1'b1;
        applyStimulus(1);
        checkLimit = 1'b0;
        pRV = 100;
        applyStimulus(20);

        $display("[TB] drain with backpressure");
        pArV = 100; pArR = 0; pRV = 80; pRR = 80;
        applyStimulus(6);
        drain = 1'b1;
        pRV = 100; pRR = 100;
        applyStimulus(10);
        pArR = 100;
        applyStimulus(60);
        expectIdle = 1'b1;
        applyStimulus(1);
        expectIdle = 1'b0;
        drain = 1'b0;

        $display("[TB] traffic after drain");
        pArV = 70; pArR = 60; pRV = 60; pRR = 60;
        applyStimulus(400);

        pArV = 0; pArR = 100; pRV = 100; pRR = 100;
        applyStimulus(60);
        expectIdle = 1'b1;
        applyStimulus(1);
        expectIdle = 1'b0;

        $display("[TB] protocol error and async reset");
        sArValid = 1'b0; mArReady = 1'b0; sRReady = 1'b1;
        mRValid = 1'b1; mRLast = 1'b1; mRData = 32'hDEAD_BEEF;
        @(negedge clk);
        cmp("err_m_rready", bus.m_rready, 1'b0);
        cmp("err_s_rvalid", bus.s_rvalid, 1'b0);
        @(posedge clk);
        #1 mRValid = 1'b0; mRLast = 1'b0;
        @(negedge clk);
        cmp("proto_err_set", protoErr, 1'b1);
        @(posedge clk);
        #1 sArValid = 1'b1; sArId = 4'd9; sArAddr = 32'h0000_2000; sArLen = 8'd0;
        @(negedge clk);
        cmp("proto_err_sticky", protoErr, 1'b1);
        cmp("err_s_arready", bus.s_arready, 1'b1);
        @(posedge clk);
        expIdQ.push_back(4'd9);
        #1 sArValid = 1'b0;
        @(negedge clk);
        cmp("pre_rst_m_arvalid", bus.m_arvalid, 1'b1);
        cmp("pre_rst_outstanding", outstanding, 1);
        #1 rst = 1'b1;
        #1;
        cmp("async_rst_proto_err", protoErr, 1'b0);
        cmp("async_rst_m_arvalid", bus.m_arvalid, 1'b0);
        cmp("async_rst_outstanding", outstanding, 0);
        cmp("async_rst_s_arready", bus.s_arready, 1'b0);
        cmp("async_rst_idle", idle, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        expIdQ.delete();
        @(negedge clk);
        cmp("post_rst_idle", idle, 1'b1);
        cmp("post_rst_s_arready", bus.s_arready, 1'b1);
        cmp("post_rst_m_rready", bus.m_rready, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
